// File: rtl/fb_palram_arb.sv
// Port-A owner of the palette RAM: arbitrates CPU accesses against a block-copy engine.
// Optional colour fade during copies is enabled with the FB_PALRAM_FADE_EN macro.
module fb_palram_arb #(
  parameter int unsigned AW     = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [7:0]    cpu_sel_i,
  input  logic [AW-1:0] cpu_adr_i,
  input  logic [63:0]   cpu_dat_i,
  output logic          cpu_ack_o,
  output logic [63:0]   cpu_dat_o,
  input  logic          cp_start_i,
  input  logic          cp_abort_i,
  input  logic [AW-1:0] cp_src_i,
  input  logic [AW-1:0] cp_dst_i,
  input  logic [AW:0]   cp_cnt_i,
  input  logic [7:0]    cp_level_i,
  output logic          cp_busy_o,
  output logic          cp_done_o,
  output logic          ram_ena_o,
  output logic [7:0]    ram_wea_o,
  output logic [AW-1:0] ram_addra_o,
  output logic [63:0]   ram_dina_o,
  input  logic [63:0]   ram_douta_i
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [3:0] {
    IDLE, CRD, CW1, CW2, CWR, CACK, ERD, EW1, EW2, EWR, DONE
  } state_t;

  state_t        state_q, nxt;
  logic          last_cpu_q;
  logic          abort_q;
  logic [AW-1:0] src_q, dst_q;
  logic [CW-1:0] cnt_q, idx_q, idx_nxt;
  logic          start_ok, start_run, abort_any, eng_pend, arb;
  logic [AW-1:0] eng_rd_adr;
  logic [63:0]   eng_data;
  logic          unused_cfg;

`ifdef FB_PALRAM_FADE_EN
  logic [7:0] level_q;

  // Colour bytes scaled by level/256, alpha bytes 3 and 7 untouched.
  function automatic logic [63:0] fade(input logic [63:0] w, input logic [7:0] lvl);
    logic [15:0] p;
    fade = w;
    for (int b = 0; b < 8; b++) begin
      if (b != 3 && b != 7) begin
        p = 16'(w[8*b +: 8]) * 16'(lvl);
        fade[8*b +: 8] = p[15:8];
      end
    end
  endfunction

  assign eng_data   = fade(ram_douta_i, level_q);
  assign unused_cfg = 1'(RD_LAT);
`else
  assign eng_data   = ram_douta_i;
  assign unused_cfg = ^{cp_level_i, 1'(RD_LAT)};
`endif

  // Next state; IDLE and a non-final EWR are the arbitration points.
  always_comb begin
    start_ok   = cp_start_i && !cp_busy_o && !cp_abort_i;
    start_run  = start_ok && (cp_cnt_i != '0);
    abort_any  = abort_q || cp_abort_i;
    idx_nxt    = CW'(idx_q + CW'(1));
    eng_pend   = cp_busy_o || start_run;
    arb        = 1'b0;
    nxt        = state_q;
    case (state_q)
      IDLE: arb = 1'b1;
      CRD:  nxt = CW1;
      CW1:  nxt = CW2;
      CW2:  nxt = CACK;
      CWR:  nxt = CACK;
      CACK: nxt = IDLE;
      ERD:  nxt = EW1;
      EW1:  nxt = EW2;
      EW2:  nxt = EWR;
      EWR: begin
        if (abort_any || idx_nxt == cnt_q) nxt = DONE;
        else arb = 1'b1;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (arb) begin
      if (cpu_req_i && (!eng_pend || !last_cpu_q)) nxt = cpu_we_i ? CWR : CRD;
      else if (eng_pend) nxt = (cp_busy_o && (abort_any || idx_q == cnt_q)) ? DONE : ERD;
      else nxt = IDLE;
    end
    // First word of a fresh copy reads straight from the start inputs.
    if (start_run) eng_rd_adr = cp_src_i;
    else if (state_q == EWR) eng_rd_adr = AW'(src_q + idx_nxt[AW-1:0]);
    else eng_rd_adr = AW'(src_q + idx_q[AW-1:0]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_cpu_q  <= 1'b0;
      abort_q     <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
`ifdef FB_PALRAM_FADE_EN
      level_q     <= '0;
`endif
      cpu_ack_o   <= 1'b0;
      cpu_dat_o   <= '0;
      cp_busy_o   <= 1'b0;
      cp_done_o   <= 1'b0;
      ram_ena_o   <= 1'b0;
      ram_wea_o   <= '0;
      ram_addra_o <= '0;
      ram_dina_o  <= '0;
    end else begin
      state_q   <= nxt;
      cpu_ack_o <= 1'b0;
      cp_done_o <= 1'b0;
      ram_ena_o <= 1'b0;
      ram_wea_o <= '0;
      if (cp_abort_i && cp_busy_o) abort_q <= 1'b1;
      if (start_ok) begin
        src_q     <= cp_src_i;
        dst_q     <= cp_dst_i;
        cnt_q     <= cp_cnt_i;
        idx_q     <= '0;
`ifdef FB_PALRAM_FADE_EN
        level_q   <= cp_level_i;
`endif
        cp_busy_o <= (cp_cnt_i != '0);
        cp_done_o <= (cp_cnt_i == '0);
      end
      if (state_q == EWR) idx_q <= idx_nxt;
      // Registered RAM/handshake outputs for the state being entered.
      case (nxt)
        CRD: begin
          ram_ena_o   <= 1'b1;
          ram_addra_o <= cpu_adr_i;
          last_cpu_q  <= 1'b1;
        end
        CWR: begin
          ram_ena_o   <= 1'b1;
          ram_wea_o   <= cpu_sel_i;
          ram_addra_o <= cpu_adr_i;
          ram_dina_o  <= cpu_dat_i;
          last_cpu_q  <= 1'b1;
        end
        CACK: begin
          cpu_ack_o <= 1'b1;
          if (state_q == CW2) cpu_dat_o <= ram_douta_i;
        end
        ERD: begin
          ram_ena_o   <= 1'b1;
          ram_addra_o <= eng_rd_adr;
          last_cpu_q  <= 1'b0;
        end
        EWR: begin
          ram_ena_o   <= 1'b1;
          ram_wea_o   <= 8'hFF;
          ram_addra_o <= AW'(dst_q + idx_q[AW-1:0]);
          ram_dina_o  <= eng_data;
        end
        DONE: begin
          cp_done_o <= 1'b1;
          cp_busy_o <= 1'b0;
          abort_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
